// File: rtl/mult_div_if.sv
// Handshake/result bundle between the EX stage and the multiply/divide unit.
// The master drives requests and MTHI/MTLO writes; the slave returns status and HI/LO.
interface mult_div_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] operand_a;
    logic [DATA_WIDTH-1:0] operand_b;
    logic                  flush;
    logic                  hi_we;
    logic                  lo_we;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
    logic                  div_by_zero;

    modport master (
        output start, op, operand_a, operand_b, flush, hi_we, lo_we, wr_data,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, operand_a, operand_b, flush, hi_we, lo_we, wr_data,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; retires BITS_PER_CYCLE bits per RUN cycle.
// state  | meaning: S_IDLE accept/MTHI/MTLO, S_RUN iterate then commit at count 0, S_FINISH done pulse
module mult_div_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic       clk,
    input logic       reset,
    mult_div_if.slave bus
);
    localparam int DW  = DATA_WIDTH;
    localparam int BPC = BITS_PER_CYCLE;
    localparam int N   = DW / BPC;
    localparam int CW  = $clog2(N + 1);
    localparam int PW  = DW + BPC;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2*DW-1:0] r_acc;
    logic [DW-1:0]   r_opd;
    logic [DW-1:0]   r_hi;
    logic [DW-1:0]   r_lo;
    logic            r_is_div;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_b_zero;
    logic            r_busy;
    logic            r_done;
    logic            r_dbz;

    logic            w_a_neg;
    logic            w_b_neg;
    logic [DW-1:0]   w_a_mag;
    logic [DW-1:0]   w_b_mag;
    logic [PW-1:0]   w_pp;
    logic [PW-1:0]   w_mul_sum;
    logic [DW-1:0]   w_rem;
    logic [DW-1:0]   w_quo;
    logic [DW:0]     w_trial;
    logic [2*DW-1:0] w_step;
    logic [2*DW-1:0] w_prod;
    logic [DW-1:0]   w_q;
    logic [DW-1:0]   w_r;
    logic [DW-1:0]   w_res_hi;
    logic [DW-1:0]   w_res_lo;

    always_comb begin
        w_a_neg = ~bus.op[0] & bus.operand_a[DW-1];
        w_b_neg = ~bus.op[0] & bus.operand_b[DW-1];
        w_a_mag = w_a_neg ? -bus.operand_a : bus.operand_a;
        w_b_mag = w_b_neg ? -bus.operand_b : bus.operand_b;
    end

    // Multiply: r_acc = {partial product, remaining multiplier}, shifted right each step.
    // Divide: r_acc = {partial remainder, remaining dividend / growing quotient}.
    always_comb begin
        w_pp      = PW'(r_opd) * PW'(r_acc[BPC-1:0]);
        w_mul_sum = PW'(r_acc[2*DW-1:DW]) + w_pp;
        w_rem     = r_acc[2*DW-1:DW];
        w_quo     = r_acc[DW-1:0];
        w_trial   = '0;
        for (int i = 0; i < BPC; i++) begin
            w_trial = {w_rem, w_quo[DW-1]} - {1'b0, r_opd};
            w_rem   = w_trial[DW] ? {w_rem[DW-2:0], w_quo[DW-1]} : w_trial[DW-1:0];
            w_quo   = {w_quo[DW-2:0], ~w_trial[DW]};
        end
        w_step = r_is_div ? {w_rem, w_quo} : {w_mul_sum, r_acc[DW-1:BPC]};
    end

    // A zero divisor leaves the dividend magnitude as remainder, so hi ends up as operand_a.
    always_comb begin
        w_prod = r_neg_q ? -r_acc : r_acc;
        w_q    = r_neg_q ? -r_acc[DW-1:0] : r_acc[DW-1:0];
        if (r_b_zero) begin
            w_q = '1;
        end
        w_r      = r_neg_r ? -r_acc[2*DW-1:DW] : r_acc[2*DW-1:DW];
        w_res_hi = r_is_div ? w_r : w_prod[2*DW-1:DW];
        w_res_lo = r_is_div ? w_q : w_prod[DW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opd    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.hi_we) begin
                        r_hi <= bus.wr_data;
                    end
                    if (bus.lo_we) begin
                        r_lo <= bus.wr_data;
                    end
                    if (bus.start && !bus.flush) begin
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                        r_cnt    <= CW'(N);
                        r_acc    <= {{DW{1'b0}}, (bus.op[1] ? w_a_mag : w_b_mag)};
                        r_opd    <= bus.op[1] ? w_b_mag : w_a_mag;
                        r_is_div <= bus.op[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_b_zero <= bus.op[1] & (bus.operand_b == '0);
                        r_dbz    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state <= S_FINISH;
                        r_done  <= 1'b1;
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                        r_dbz   <= r_b_zero;
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: unit 0 is DW=32/BPC=1, unit 1 is DW=16/BPC=4.
// Issued ops push hand-computed results; per-unit monitors pop and compare on done.
module tb_mult_div_unit;
    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic [1:0]  rst = 2'b11;
    logic        st[2];
    logic        fl[2];
    logic        hwe[2];
    logic        lwe[2];
    logic [1:0]  opv[2];
    logic [31:0] av[2];
    logic [31:0] bv[2];
    logic [31:0] wd[2];
    logic [31:0] hi_o[2];
    logic [31:0] lo_o[2];
    logic        busy_o[2];
    logic        done_o[2];
    logic        dbz_o[2];

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb0[$];
    exp_t sb1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_div_if #(.DATA_WIDTH(32)) if0 ();
    mult_div_if #(.DATA_WIDTH(16)) if1 ();

    mult_div_unit #(.DATA_WIDTH(32), .BITS_PER_CYCLE(1)) dut0 (.clk(clk), .reset(rst[0]), .bus(if0.slave));
    mult_div_unit #(.DATA_WIDTH(16), .BITS_PER_CYCLE(4)) dut1 (.clk(clk), .reset(rst[1]), .bus(if1.slave));

    assign if0.start     = st[0];
    assign if0.op        = opv[0];
    assign if0.operand_a = av[0];
    assign if0.operand_b = bv[0];
    assign if0.flush     = fl[0];
    assign if0.hi_we     = hwe[0];
    assign if0.lo_we     = lwe[0];
    assign if0.wr_data   = wd[0];
    assign if1.start     = st[1];
    assign if1.op        = opv[1];
    assign if1.operand_a = av[1][15:0];
    assign if1.operand_b = bv[1][15:0];
    assign if1.flush     = fl[1];
    assign if1.hi_we     = hwe[1];
    assign if1.lo_we     = lwe[1];
    assign if1.wr_data   = wd[1][15:0];

    assign hi_o[0]   = if0.hi;
    assign lo_o[0]   = if0.lo;
    assign busy_o[0] = if0.busy;
    assign done_o[0] = if0.done;
    assign dbz_o[0]  = if0.div_by_zero;
    assign hi_o[1]   = {16'h0000, if1.hi};
    assign lo_o[1]   = {16'h0000, if1.lo};
    assign busy_o[1] = if1.busy;
    assign done_o[1] = if1.done;
    assign dbz_o[1]  = if1.div_by_zero;

    function automatic logic [31:0] mask(input int u);
        return (u == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    function automatic int nb(input int u);
        return (u == 0) ? 32 : 4;
    endfunction

    task automatic chk(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s unit%0d: got %h expected %h", name, u, act, exp);
        end
    endtask

    task automatic mon(input int u);
        exp_t e;
        int   sz;
        sz = (u == 0) ? sb0.size() : sb1.size();
        if (sz == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done unit%0d: got done=1 expected no done (hi=%h lo=%h)", u, hi_o[u], lo_o[u]);
        end else begin
            if (u == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            chk("result_hi", u, hi_o[u], e.hi);
            chk("result_lo", u, lo_o[u], e.lo);
            chk("result_dbz", u, {31'b0, dbz_o[u]}, {31'b0, e.dbz});
            chk("latency_cycle", u, cyc, e.cyc);
        end
    endtask

    always @(negedge clk) if (done_o[0]) mon(0);
    always @(negedge clk) if (done_o[1]) mon(1);

    task automatic wait_idle(input int u);
        int n = 0;
        @(negedge clk);
        while (busy_o[u] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy_o[u]) chk("idle_timeout", u, {31'b0, busy_o[u]}, 32'd0);
    endtask

    task automatic issue(input int u, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edbz, input bit push);
        exp_t e;
        wait_idle(u);
        st[u]  = 1'b1;
        opv[u] = op;
        av[u]  = a;
        bv[u]  = b;
        if (push) begin
            e.hi  = ehi;
            e.lo  = elo;
            e.dbz = edbz;
            e.cyc = cyc + nb(u) + 2;
            if (u == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
        @(negedge clk);
        st[u] = 1'b0;
    endtask

    task automatic run_unit(input int u);
        logic [31:0] m;
        logic [31:0] msb;
        int          n;
        m   = mask(u);
        msb = m ^ (m >> 1);

        issue(u, OP_MULTU, m, m, m - 32'd1, 32'd1, 1'b0, 1'b1);
        issue(u, OP_MULT, m - 32'd2, 32'd7, m, m - 32'd20, 1'b0, 1'b1);
        issue(u, OP_MULT, msb, msb, msb >> 1, 32'd0, 1'b0, 1'b1);
        issue(u, OP_DIV, m - 32'd6, 32'd2, m, m - 32'd2, 1'b0, 1'b1);
        issue(u, OP_DIV, 32'd7, m - 32'd1, 32'd1, m - 32'd2, 1'b0, 1'b1);
        issue(u, OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
        issue(u, OP_DIV, msb, m, 32'd0, msb, 1'b0, 1'b1);
        issue(u, OP_DIVU, 32'd5, 32'd0, 32'd5, m, 1'b1, 1'b1);
        wait_idle(u);
        chk("dbz_sticky", u, {31'b0, dbz_o[u]}, 32'd1);
        issue(u, OP_DIV, m - 32'd4, 32'd0, m - 32'd4, m, 1'b1, 1'b1);
        issue(u, OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b1);
        chk("dbz_clear_on_accept", u, {31'b0, dbz_o[u]}, 32'd0);

        wait_idle(u);
        hwe[u] = 1'b1;
        wd[u]  = 32'h1234_5678;
        @(negedge clk);
        hwe[u] = 1'b0;
        chk("mthi", u, hi_o[u], 32'h1234_5678 & m);
        lwe[u] = 1'b1;
        wd[u]  = 32'hCAFE_F00D;
        @(negedge clk);
        lwe[u] = 1'b0;
        chk("mtlo", u, lo_o[u], 32'hCAFE_F00D & m);

        issue(u, OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b1);
        st[u]  = 1'b1;
        opv[u] = OP_DIVU;
        av[u]  = 32'd1;
        bv[u]  = 32'd1;
        hwe[u] = 1'b1;
        wd[u]  = 32'hDEAD_BEEF;
        @(negedge clk);
        st[u]  = 1'b0;
        hwe[u] = 1'b0;
        chk("hi_we_while_busy", u, hi_o[u], 32'h1234_5678 & m);
        chk("busy_in_run", u, {31'b0, busy_o[u]}, 32'd1);

        issue(u, OP_MULT, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (((u == 0) ? 10 : 3) - 1) @(negedge clk);
        fl[u] = 1'b1;
        @(negedge clk);
        fl[u] = 1'b0;
        chk("flush_busy", u, {31'b0, busy_o[u]}, 32'd0);
        chk("flush_hi_hold", u, hi_o[u], 32'd0);
        chk("flush_lo_hold", u, lo_o[u], 32'd42);
        repeat (nb(u) + 4) @(negedge clk);

        fl[u]  = 1'b1;
        st[u]  = 1'b1;
        opv[u] = OP_MULTU;
        av[u]  = 32'd2;
        bv[u]  = 32'd2;
        @(negedge clk);
        st[u] = 1'b0;
        fl[u] = 1'b0;
        chk("flush_blocks_start", u, {31'b0, busy_o[u]}, 32'd0);
        repeat (nb(u) + 4) @(negedge clk);

        issue(u, OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b1);
        n = 0;
        while (!done_o[u] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", u, {31'b0, done_o[u]}, 32'd1);
        fl[u] = 1'b1;
        @(negedge clk);
        fl[u] = 1'b0;
        chk("flush_in_finish_idle", u, {31'b0, busy_o[u]}, 32'd0);
        chk("flush_in_finish_lo", u, lo_o[u], 32'd6);

        issue(u, OP_MULTU, 32'd4, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst[u] = 1'b1;
        #1;
        chk("async_rst_busy", u, {31'b0, busy_o[u]}, 32'd0);
        chk("async_rst_lo", u, lo_o[u], 32'd0);
        chk("async_rst_done", u, {31'b0, done_o[u]}, 32'd0);
        rst[u] = 1'b0;
        repeat (nb(u) + 4) @(negedge clk);
        chk("sb_drain", u, (u == 0) ? sb0.size() : sb1.size(), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            st[i]  = 1'b0;
            fl[i]  = 1'b0;
            hwe[i] = 1'b0;
            lwe[i] = 1'b0;
            opv[i] = 2'd0;
            av[i]  = 32'd0;
            bv[i]  = 32'd0;
            wd[i]  = 32'd0;
        end
        rst = 2'b11;
        repeat (3) @(negedge clk);
        rst = 2'b00;
        for (int u = 0; u < 2; u++) begin
            chk("reset_busy", u, {31'b0, busy_o[u]}, 32'd0);
            chk("reset_done", u, {31'b0, done_o[u]}, 32'd0);
            chk("reset_hi", u, hi_o[u], 32'd0);
            chk("reset_lo", u, lo_o[u], 32'd0);
            chk("reset_dbz", u, {31'b0, dbz_o[u]}, 32'd0);
        end
        run_unit(0);
        run_unit(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
